phy_tx_serializer: RTL and testbench
====================================

Name: phy_tx_serializer

Overview:
- Transmit half of the PHY lane; the counterpart of the receive path (serial-to-parallel, COM alignment, 1x4 byte demux).
- Takes four 8-bit byte lanes, each with a valid flag, and time-multiplexes them round-robin into one byte stream. Serializes that stream MSB-first at one bit per clk.
- Sends COM (0xBC) when the current lane has no data, and sends a COM preamble after reset so the far-end receiver can align and go active.
- Runs entirely on the bit-rate clock.

Parameters:
- COM_CHAR, 8'hBC, comma/idle byte; the receiver aligns on it and discards it.
- PREAMBLE_BYTES, 4, number of COM bytes sent after reset before lane data may be sent (range 1..15).

Ports:
- clk  input  1  bit clock, one serial bit per rising edge.
- reset  input  1  reset, synchronous and active-high.
- data_in0..data_in3  input  8 each  lane bytes; must be held stable while the matching valid_in is high and ack has not yet pulsed.
- valid_in0..valid_in3  input  1 each  lane has a byte to send.
- ack0..ack3  output  1 each  one-cycle pulse; the lane byte was captured this cycle and upstream may advance.
- data_out  output  1  serial stream, MSB first, registered.
- active_out  output  1  high once the preamble is complete.
- k_collision  output  1  one-cycle pulse; a captured lane byte equals COM_CHAR.

Behaviour:
- Synchronous reset (active-high); all registers update only on rising clk. Reset values:
  - data_out=0, active_out=0, ack*=0, k_collision=0.
  - shreg=0, bit_cnt=7, lane_sel=0, pre_cnt=0, state=SYNC.
- Bit counter:
  - bit_cnt decrements 7→0 and wraps; the cycle with bit_cnt==7 is the load cycle.
  - Load cycle: data_out<=next_byte[7], shreg<={next_byte[6:0],1'b0}.
  - Other cycles: data_out<=shreg[7], shreg<=shreg<<1.
  - Result: contiguous 8-bit frames with no gap bits; a byte loaded at cycle N appears on data_out in cycles N+1..N+8.
- State SYNC:
  - next_byte=COM_CHAR.
  - pre_cnt increments on each load cycle.
  - When the load cycle with pre_cnt==PREAMBLE_BYTES-1 occurs: state<=ACTIVE and active_out<=1 in the same edge.
  - lane_sel stays frozen at 0; no ack is issued.
- State ACTIVE, on each load cycle:
  - If valid_in[lane_sel]: next_byte=data_in[lane_sel], ack[lane_sel]=1 for that cycle only.
  - Otherwise: next_byte=COM_CHAR and no ack.
  - lane_sel<=lane_sel+1 mod 4, unconditionally.
  - Lane order on the wire is therefore fixed at 0,1,2,3,0,… with COM filling empty slots, which keeps the far-end demux lane-aligned.
- ack timing: ack and k_collision are combinational from the state, bit_cnt, lane_sel and valid signals, and are high only in the load cycle. At most one ack is high in any cycle.
- Valid asserted mid-byte: the byte is not sampled until that lane's next slot, a wait of up to 31 cycles.
- Data equal to COM_CHAR: transmitted unchanged and ack'd; k_collision pulses in the same cycle. The far end will drop this byte. Upstream is responsible for avoiding it.
- Reset mid-byte: the current byte is truncated. data_out=0 on the next cycle; the preamble restarts from pre_cnt=0 and lane_sel restarts at 0.
- reset and valid high in the same cycle: reset wins and no ack is issued.
- Simultaneous valid on several lanes: only lane_sel is served; the other lanes wait for their slots.

Decomposition:
- Shared include phy_defines.vh holds:
  - COM_CHAR (8'hBC), shared with the receive path.
  - NUM_LANES=4 and the lane index width (2).
  - State encoding: SYNC=1'b0, ACTIVE=1'b1.
- One sub-module, phy_tx_piso: 8-bit load/shift register plus bit_cnt. Inputs clk, reset, load_byte[7:0]. Outputs data_out and load_cycle.
- The top level holds the state machine, preamble counter, lane arbiter and ack/k_collision logic.

Test Plan:
- Reset, then hold all valid low for 64 cycles → cycles 1..32 show 0xBC four times MSB-first (1,0,1,1,1,1,0,0); active_out rises at the edge ending cycle 24; 0xBC continues afterwards; no ack.
- Preamble done, lane0 valid with 0x5A, others idle → ack0 pulses in the first ACTIVE load cycle; next 8 bits are 0,1,0,1,1,0,1,0; then three 0xBC slots (lanes 1–3).
- All lanes valid continuously with 0x11, 0x22, 0x33, 0x44 → stream 11,22,33,44 repeating; ack0..ack3 each pulse once per 32 cycles, 8 cycles apart, never overlapping.
- valid_in2 rises 3 cycles into lane-0 slot with 0xA5 → ack2 fires 13 cycles later at the lane-2 load; 0xA5 is emitted with no earlier sampling.
- lane1 valid with 0xBC → byte sent unchanged; ack1 and k_collision both pulse in the same cycle.
- Reset asserted 3 cycles into a data byte → data_out=0 and active_out=0 on the next cycle; after release, a fresh 4-byte preamble runs and lane order restarts at lane 0.

Source files
------------

// File: rtl/phy_tx_serializer_pkg.sv
// Shared definitions for the PHY transmit lane: comma character, lane
// geometry and the transmit state encoding (mirrors the receive path).
package phy_tx_serializer_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PHY_COM_CHAR = 8'hBC;
  localparam int NUM_LANES = 4;
  localparam int LANE_W = 2;
  localparam int PRE_CNT_W = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

  typedef logic [LANE_W-1:0] lane_idx_t;

  // One-hot ack vector for the lane currently being served.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
    return NUM_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/phy_tx_serializer_piso.sv
// 8-bit parallel-in serial-out shifter with its own bit counter.
// The cycle where bit_cnt is 7 is the load cycle; frames are back to back.
module phy_tx_piso
  import phy_tx_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] load_byte,
  output logic              data_out,
  output logic              load_cycle
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              data_out_q, data_out_d;

  // Load the MSB straight onto the wire in the load cycle, otherwise shift.
  always_comb begin
    load_cycle = (bit_cnt_q == 3'd7);
    bit_cnt_d  = bit_cnt_q - 3'd1;
    if (load_cycle) begin
      data_out_d = load_byte[BYTE_W-1];
      shreg_d    = {load_byte[BYTE_W-2:0], 1'b0};
    end else begin
      data_out_d = shreg_q[BYTE_W-1];
      shreg_d    = {shreg_q[BYTE_W-2:0], 1'b0};
    end
  end

  // Shift register, bit counter and output flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q    <= '0;
      bit_cnt_q  <= 3'd7;
      data_out_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/phy_tx_serializer.sv
// PHY transmit lane: sends a COM preamble after reset, then serves four
// byte lanes round-robin, filling empty slots with COM, MSB first.
module phy_tx_serializer
  import phy_tx_serializer_pkg::*;
#(
  parameter logic [7:0] COM_CHAR       = PHY_COM_CHAR,
  parameter int         PREAMBLE_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  output logic       ack0,
  output logic       ack1,
  output logic       ack2,
  output logic       ack3,
  output logic       data_out,
  output logic       active_out,
  output logic       k_collision
);

  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PREAMBLE_BYTES - 1);

  tx_state_e             state_q, state_d;
  logic [PRE_CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  lane_idx_t             lane_sel_q, lane_sel_d;
  logic                  active_q, active_d;

  logic [BYTE_W-1:0]     lane_data [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_valid;
  logic [NUM_LANES-1:0]  ack_vec;
  logic [BYTE_W-1:0]     next_byte;
  logic                  load_cycle;

  // Gather the individual lane ports into indexable form.
  always_comb begin
    lane_data[0] = data_in0;
    lane_data[1] = data_in1;
    lane_data[2] = data_in2;
    lane_data[3] = data_in3;
    lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};
  end

  // Preamble sequencing, lane arbitration, byte selection and ack strobes.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    lane_sel_d  = lane_sel_q;
    active_d    = active_q;
    next_byte   = COM_CHAR;
    ack_vec     = '0;
    k_collision = 1'b0;
    case (state_q)
      SYNC: begin
        if (load_cycle) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (load_cycle) begin
          lane_sel_d = lane_sel_q + 1'b1;
          // Reset suppresses the ack so upstream never loses a byte.
          if (lane_valid[lane_sel_q] && !reset) begin
            next_byte   = lane_data[lane_sel_q];
            ack_vec     = lane_onehot(lane_sel_q);
            k_collision = (lane_data[lane_sel_q] == COM_CHAR);
          end
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      pre_cnt_q  <= '0;
      lane_sel_q <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      lane_sel_q <= lane_sel_d;
      active_q   <= active_d;
    end
  end

  phy_tx_piso u_piso (
    .clk        (clk),
    .reset      (reset),
    .load_byte  (next_byte),
    .data_out   (data_out),
    .load_cycle (load_cycle)
  );

  assign {ack3, ack2, ack1, ack0} = ack_vec;
  assign active_out = active_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Scoreboard bench for phy_tx_serializer: stimulus pushes the expected
// byte and ack pattern of every slot; a negedge monitor deserializes the
// line and checks bytes, ack/k_collision strobes and active_out.
module tb_phy_tx_serializer;

  localparam logic [7:0] COM = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
  logic       ack0, ack1, ack2, ack3;
  logic       data_out, active_out, k_collision;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_bytes [$];
  logic [4:0] exp_acks [$];

  int         cyc = 0;
  bit         rst_prev = 1'b0;
  logic [7:0] acc = '0;
  logic [7:0] eb;
  logic [4:0] ea;

  phy_tx_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .data_in0    (data_in0),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .data_in3    (data_in3),
    .valid_in0   (valid_in0),
    .valid_in1   (valid_in1),
    .valid_in2   (valid_in2),
    .valid_in3   (valid_in3),
    .ack0        (ack0),
    .ack1        (ack1),
    .ack2        (ack2),
    .ack3        (ack3),
    .data_out    (data_out),
    .active_out  (active_out),
    .k_collision (k_collision)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (t=%0t, cyc=%0d)", name, actual, expected, $time, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
    {valid_in3, valid_in2, valid_in1, valid_in0} = v;
    data_in0 = d0;
    data_in1 = d1;
    data_in2 = d2;
    data_in3 = d3;
  endtask

  task automatic expectSlot(input logic [7:0] b, input logic [3:0] ack, input logic k);
    exp_bytes.push_back(b);
    exp_acks.push_back({k, ack});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sample mid-cycle, rebuild bytes and pop the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("ack_during_reset", {3'b000, k_collision, ack3, ack2, ack1, ack0}, 8'h00);
      if (rst_prev) begin
        checkOutput("data_out_in_reset", {7'b0, data_out}, 8'h00);
        checkOutput("active_in_reset", {7'b0, active_out}, 8'h00);
      end
      exp_bytes.delete();
      exp_acks.delete();
      rst_prev = 1'b1;
      cyc = 0;
      acc = '0;
    end else begin
      if (rst_prev) begin
        cyc = 0;
        checkOutput("data_out_after_reset", {7'b0, data_out}, 8'h00);
      end else begin
        cyc++;
      end
      rst_prev = 1'b0;
      if (cyc >= 1) acc = {acc[6:0], data_out};
      if (cyc >= 8 && cyc % 8 == 0) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          failures++;
          $display("[TB] FAIL byte_underflow: got byte 0x%02h, expected none queued (cyc=%0d)", acc, cyc);
        end else begin
          eb = exp_bytes.pop_front();
          checkOutput("serial_byte", acc, eb);
        end
      end
      if (cyc % 8 == 0) begin
        checks++;
        if (exp_acks.size() == 0) begin
          failures++;
          $display("[TB] FAIL ack_underflow: got load cycle, expected none queued (cyc=%0d)", cyc);
        end else begin
          ea = exp_acks.pop_front();
          checkOutput("load_ack_kcol", {3'b000, k_collision, ack3, ack2, ack1, ack0}, {3'b000, ea});
        end
      end else begin
        checkOutput("ack_outside_load", {3'b000, k_collision, ack3, ack2, ack1, ack0}, 8'h00);
      end
      checkOutput("active_out", {7'b0, active_out}, {7'b0, (cyc >= 25)});
    end
  end

  initial begin
    $display("[TB] phy_tx_serializer scoreboard bench");
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    waitCycles(3);
    reset = 1'b0;

    // Preamble plus one idle round: eight COM bytes, no acks.
    for (int i = 0; i < 8; i++) begin
      expectSlot(COM, 4'b0000, 1'b0);
      waitCycles(8);
    end

    // Lane 0 only with 0x5A, then three COM fillers.
    applyStimulus(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
    expectSlot(8'h5A, 4'b0001, 1'b0);
    waitCycles(1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    waitCycles(7);
    for (int i = 0; i < 3; i++) begin
      expectSlot(COM, 4'b0000, 1'b0);
      waitCycles(8);
    end

    // All lanes valid for two rounds.
    applyStimulus(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    for (int r = 0; r < 2; r++) begin
      expectSlot(8'h11, 4'b0001, 1'b0); waitCycles(8);
      expectSlot(8'h22, 4'b0010, 1'b0); waitCycles(8);
      expectSlot(8'h33, 4'b0100, 1'b0); waitCycles(8);
      expectSlot(8'h44, 4'b1000, 1'b0); waitCycles(8);
    end

    // Lane 2 goes valid three cycles into the lane-0 slot.
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    expectSlot(COM, 4'b0000, 1'b0);
    waitCycles(3);
    applyStimulus(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    waitCycles(5);
    expectSlot(COM, 4'b0000, 1'b0);
    waitCycles(8);
    expectSlot(8'hA5, 4'b0100, 1'b0);
    waitCycles(1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    waitCycles(7);
    expectSlot(COM, 4'b0000, 1'b0);
    waitCycles(8);

    // Lane 1 carries the comma character itself.
    expectSlot(COM, 4'b0000, 1'b0);
    waitCycles(8);
    applyStimulus(4'b0010, 8'h00, 8'hBC, 8'h00, 8'h00);
    expectSlot(8'hBC, 4'b0010, 1'b1);
    waitCycles(1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    waitCycles(7);
    expectSlot(COM, 4'b0000, 1'b0); waitCycles(8);
    expectSlot(COM, 4'b0000, 1'b0); waitCycles(8);

    // Reset three cycles into a lane-0 data byte.
    applyStimulus(4'b0001, 8'hC3, 8'h00, 8'h00, 8'h00);
    expectSlot(8'hC3, 4'b0001, 1'b0);
    waitCycles(1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectSlot(COM, 4'b0000, 1'b0);
      waitCycles(8);
    end
    applyStimulus(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    expectSlot(8'h01, 4'b0001, 1'b0); waitCycles(8);
    expectSlot(8'h02, 4'b0010, 1'b0); waitCycles(8);
    expectSlot(8'h03, 4'b0100, 1'b0); waitCycles(8);
    expectSlot(8'h04, 4'b1000, 1'b0); waitCycles(8);

    // Reset coincides with a valid lane-0 load cycle; valid stays up during preamble.
    applyStimulus(4'b0001, 8'h77, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectSlot(COM, 4'b0000, 1'b0);
      waitCycles(8);
    end
    expectSlot(8'h77, 4'b0001, 1'b0);
    waitCycles(1);
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    waitCycles(7);
    expectSlot(COM, 4'b0000, 1'b0); waitCycles(8);
    expectSlot(COM, 4'b0000, 1'b0); waitCycles(8);
    expectSlot(COM, 4'b0000, 1'b0);
    waitCycles(1);

    checkOutput("ack_queue_left", 8'(exp_acks.size()), 8'd0);
    checkOutput("byte_queue_left", 8'(exp_bytes.size()), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
